// File: rtl/seg7_pkg.sv
// Shared types, constants and the lit-high seven-segment table for the digit counter display.
// Segment order is bit0=a .. bit6=g.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [3:0] digit_t;

  localparam seg_t   SEG_BLANK     = 7'h00;
  localparam digit_t DIGIT_MAX_HEX = 4'd15;
  localparam digit_t DIGIT_MAX_BCD = 4'd9;

  function automatic seg_t seg7_encode(input digit_t d);
    seg_t s;
    case (d)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/counter_digit.sv
// One HEX/BCD counter digit with synchronous load; steps on the clock after step=1.
// carry_out is combinational: step qualified by the digit sitting at its terminal value.
module counter_digit
  import seg7_pkg::*;
(
  input  logic   clock,
  input  logic   reset,
  input  logic   step,
  input  logic   up_down,
  input  logic   radix_bcd,
  input  logic   load,
  input  digit_t load_nibble,
  output digit_t digit,
  output logic   carry_out
);

  digit_t max_val;
  digit_t next_val;
  digit_t load_clamped;
  logic   at_term;

  always_comb begin
    max_val  = radix_bcd ? DIGIT_MAX_BCD : DIGIT_MAX_HEX;
    // ">=" lets an out-of-range BCD digit roll to 0 with carry when counting up
    at_term  = up_down ? (digit >= max_val) : (digit == 4'd0);
    if (up_down)
      next_val = at_term ? 4'd0 : digit + 4'd1;
    else if (at_term)
      next_val = max_val;
    else if (digit > max_val)
      next_val = 4'd8;
    else
      next_val = digit - 4'd1;
    load_clamped = (radix_bcd && (load_nibble > DIGIT_MAX_BCD)) ? DIGIT_MAX_BCD : load_nibble;
  end

  assign carry_out = step & at_term;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      digit <= 4'd0;
    else if (load)
      digit <= load_clamped;
    else if (step)
      digit <= next_val;
  end

endmodule

// File: rtl/seg7_counter_display.sv
// N-digit up/down counter with clock-enable prescaler, ripple carry and registered 7-seg decode.
// count steps the clock after tick; hex follows count and blank_lz by one register stage.
module seg7_counter_display
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int DIV_WIDTH  = 23,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    up_down,
  input  logic                    radix_bcd,
  input  logic                    blank_lz,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  output logic [4*NUM_DIGITS-1:0] count,
  output logic [7*NUM_DIGITS-1:0] hex,
  output logic                    tick,
  output logic                    wrap
);

  logic [DIV_WIDTH-1:0]    prescaler;
  logic [NUM_DIGITS:0]     carry;
  logic [7*NUM_DIGITS-1:0] hex_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prescaler <= '0;
      tick      <= 1'b0;
    end else begin
      tick <= enable & (&prescaler);
      if (enable)
        prescaler <= prescaler + DIV_WIDTH'(1);
    end
  end

  assign carry[0] = tick;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    counter_digit u_digit (
      .clock       (clock),
      .reset       (reset),
      .step        (carry[g]),
      .up_down     (up_down),
      .radix_bcd   (radix_bcd),
      .load        (load),
      .load_nibble (load_value[4*g +: 4]),
      .digit       (count[4*g +: 4]),
      .carry_out   (carry[g+1])
    );
  end

  // A load swallows the coincident step, so its carry-out must not flag a wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      wrap <= 1'b0;
    else
      wrap <= carry[NUM_DIGITS] & ~load;
  end

  always_comb begin
    logic upper_zero;
    seg_t seg;
    hex_next   = '0;
    upper_zero = 1'b1;
    seg        = SEG_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (count[4*i +: 4] == 4'd0);
      seg        = seg7_encode(count[4*i +: 4]);
      if (blank_lz && (i != 0) && upper_zero)
        seg = SEG_BLANK;
      hex_next[7*i +: 7] = ACTIVE_LOW ? ~seg : seg;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      hex <= {(7*NUM_DIGITS){ACTIVE_LOW}};
    else
      hex <= hex_next;
  end

endmodule

// File: tb/tb_seg7_counter_display.sv
// Bench for seg7_counter_display: directed scenarios plus random stimulus against a value-level model.
module tb_seg7_counter_display;

  localparam int ND      = 4;
  localparam int DW      = 2;
  localparam int PERIOD  = 1 << DW;
  localparam int BCD_MOD = 10000;
  localparam logic [6:0] SEG_TAB [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0, up_down = 1'b1, radix_bcd = 1'b0, blank_lz = 1'b0, load = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] count, count0;
  logic [27:0] hex, hex0;
  logic        tick, wrap, tick0, wrap0;

  int n_cmp = 0;
  int n_fail = 0;

  seg7_counter_display #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .radix_bcd(radix_bcd),
    .blank_lz(blank_lz), .load(load), .load_value(load_value),
    .count(count), .hex(hex), .tick(tick), .wrap(wrap));

  seg7_counter_display #(.NUM_DIGITS(ND), .DIV_WIDTH(DW), .ACTIVE_LOW(1'b0)) dut0 (
    .clock(clock), .reset(reset), .enable(enable), .up_down(up_down), .radix_bcd(radix_bcd),
    .blank_lz(blank_lz), .load(load), .load_value(load_value),
    .count(count0), .hex(hex0), .tick(tick0), .wrap(wrap0));

  always #5 clock = ~clock;

  // ---------------- reference model (counter value as a number) ----------------
  int          m_pre;
  logic        m_tick, m_wrap;
  logic [15:0] m_count;
  logic [27:0] m_lit;

  function automatic logic [27:0] model_lit(input logic [15:0] c, input logic blz);
    logic [27:0] r;
    r = '0;
    for (int i = 0; i < ND; i++)
      if (!(blz && i > 0 && (c >> (4*i)) == 16'd0))
        r[7*i +: 7] = SEG_TAB[c[4*i +: 4]];
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [15:0] c);
    for (int i = 0; i < ND; i++)
      if (c[4*i +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd_val(input logic [15:0] c);
    int v = 0;
    for (int i = ND - 1; i >= 0; i--) v = v * 10 + int'(c[4*i +: 4]);
    return v;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int t = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [15:0] clamp_fn(input logic [15:0] v, input logic bcd);
    logic [15:0] r = v;
    for (int i = 0; i < ND; i++)
      if (bcd && r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    return r;
  endfunction

  // returns {wrap, new_count}
  function automatic logic [16:0] step_fn(input logic [15:0] c, input logic up, input logic bcd);
    logic [15:0] r;
    logic        w, cy;
    logic [3:0]  d;
    int          v;
    if (!bcd) begin
      w = up ? (c == 16'hFFFF) : (c == 16'h0000);
      r = up ? c + 16'd1 : c - 16'd1;
    end else if (bcd_valid(c)) begin
      v = bcd_val(c);
      w = up ? (v == BCD_MOD - 1) : (v == 0);
      v = up ? (v + 1) % BCD_MOD : (v + BCD_MOD - 1) % BCD_MOD;
      r = to_bcd(v);
    end else begin
      // out-of-range BCD digits: apply the per-digit rules lowest digit first
      r  = c;
      cy = 1'b1;
      for (int i = 0; i < ND; i++) begin
        if (cy) begin
          d = r[4*i +: 4];
          if (up) begin
            if (d >= 4'd9) r[4*i +: 4] = 4'd0;
            else begin r[4*i +: 4] = d + 4'd1; cy = 1'b0; end
          end else begin
            if (d == 4'd0) r[4*i +: 4] = 4'd9;
            else if (d > 4'd9) begin r[4*i +: 4] = 4'd8; cy = 1'b0; end
            else begin r[4*i +: 4] = d - 4'd1; cy = 1'b0; end
          end
        end
      end
      w = cy;
    end
    return {w, r};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_pre   <= 0;
      m_tick  <= 1'b0;
      m_wrap  <= 1'b0;
      m_count <= '0;
      m_lit   <= '0;
    end else begin
      m_tick <= enable && (m_pre == PERIOD - 1);
      m_pre  <= enable ? (m_pre + 1) % PERIOD : m_pre;
      m_lit  <= model_lit(m_count, blank_lz);
      if (load) begin
        m_count <= clamp_fn(load_value, radix_bcd);
        m_wrap  <= 1'b0;
      end else if (m_tick) begin
        {m_wrap, m_count} <= step_fn(m_count, up_down, radix_bcd);
      end else begin
        m_wrap <= 1'b0;
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    enable = 1'b1; up_down = 1'b1; radix_bcd = 1'b0;
    repeat (7) cyc();
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (count !== 16'h0000) begin n_fail++; $display("FAIL reset_count: got %h expected 0000", count); end
    n_cmp++; if (hex !== 28'hFFFFFFF) begin n_fail++; $display("FAIL reset_hex: got %h expected fffffff", hex); end
    n_cmp++; if (hex0 !== 28'h0000000) begin n_fail++; $display("FAIL reset_hex_ah: got %h expected 0000000", hex0); end
    n_cmp++; if (tick !== 1'b0 || wrap !== 1'b0) begin n_fail++; $display("FAIL reset_tick_wrap: got %b%b expected 00", tick, wrap); end
    @(negedge clock);
    reset = 1'b0; blank_lz = 1'b0; enable = 1'b0;
    cyc();
    n_cmp++; if (hex !== {4{7'h40}}) begin n_fail++; $display("FAIL reset_decode: got %h expected %h", hex, {4{7'h40}}); end
    n_cmp++; if (hex0 !== {4{7'h3F}}) begin n_fail++; $display("FAIL reset_decode_ah: got %h expected %h", hex0, {4{7'h3F}}); end
  endtask

  task automatic test_bcd_wrap();
    int k;
    enable = 1'b1; up_down = 1'b1; radix_bcd = 1'b1;
    load = 1'b1; load_value = 16'h9999;
    cyc();
    load = 1'b0;
    n_cmp++; if (count !== 16'h9999) begin n_fail++; $display("FAIL bcd_load: got %h expected 9999", count); end
    k = 0;
    while (tick !== 1'b1 && k < 2*PERIOD) begin cyc(); k++; end
    n_cmp++; if (tick !== 1'b1) begin n_fail++; $display("FAIL bcd_tick_timeout: got tick=%b expected 1", tick); end
    cyc();
    n_cmp++; if (count !== 16'h0000) begin n_fail++; $display("FAIL bcd_wrap_count: got %h expected 0000", count); end
    n_cmp++; if (wrap !== 1'b1) begin n_fail++; $display("FAIL bcd_wrap_pulse: got %b expected 1", wrap); end
    cyc();
    n_cmp++; if (hex[6:0] !== 7'h40) begin n_fail++; $display("FAIL bcd_wrap_hex0: got %h expected 40", hex[6:0]); end
    n_cmp++; if (wrap !== 1'b0) begin n_fail++; $display("FAIL bcd_wrap_one_cycle: got %b expected 0", wrap); end
    k = 0;
    while (tick !== 1'b1 && k < 2*PERIOD) begin cyc(); k++; end
    k = 0;
    do begin cyc(); k++; end while (tick !== 1'b1 && k < 2*PERIOD);
    n_cmp++; if (k != PERIOD) begin n_fail++; $display("FAIL tick_period: got %0d expected %0d", k, PERIOD); end
  endtask

  task automatic test_hex_carry();
    int k;
    enable = 1'b1; up_down = 1'b1; radix_bcd = 1'b0;
    load = 1'b1; load_value = 16'h00FF;
    cyc();
    load = 1'b0;
    for (int s = 0; s < 2; s++) begin
      k = 0;
      while (tick !== 1'b1 && k < 2*PERIOD) begin cyc(); k++; end
      cyc();
      n_cmp++;
      if (count !== (s == 0 ? 16'h0100 : 16'h0101) || wrap !== 1'b0) begin
        n_fail++; $display("FAIL hex_carry_%0d: got %h wrap=%b expected %h wrap=0", s, count, wrap, (s == 0 ? 16'h0100 : 16'h0101));
      end
    end
  endtask

  task automatic test_down_wrap();
    int k;
    enable = 1'b1; up_down = 1'b0;
    for (int r = 0; r < 2; r++) begin
      radix_bcd = (r == 0);
      load = 1'b1; load_value = 16'h0000;
      cyc();
      load = 1'b0;
      k = 0;
      while (tick !== 1'b1 && k < 2*PERIOD) begin cyc(); k++; end
      cyc();
      n_cmp++;
      if (count !== (r == 0 ? 16'h9999 : 16'hFFFF) || wrap !== 1'b1) begin
        n_fail++; $display("FAIL down_wrap_%s: got %h wrap=%b expected %h wrap=1", (r == 0 ? "bcd" : "hex"), count, wrap, (r == 0 ? 16'h9999 : 16'hFFFF));
      end
    end
  endtask

  task automatic test_blanking();
    enable = 1'b0; blank_lz = 1'b1; radix_bcd = 1'b0;
    load = 1'b1; load_value = 16'h0050;
    cyc();
    load = 1'b0;
    cyc();
    n_cmp++; if (hex !== {7'h7F, 7'h7F, 7'h12, 7'h40}) begin n_fail++; $display("FAIL blank_0050: got %h expected %h", hex, {7'h7F, 7'h7F, 7'h12, 7'h40}); end
    n_cmp++; if (hex0 !== {7'h00, 7'h00, 7'h6D, 7'h3F}) begin n_fail++; $display("FAIL blank_0050_ah: got %h expected %h", hex0, {7'h00, 7'h00, 7'h6D, 7'h3F}); end
    load = 1'b1; load_value = 16'h0000;
    cyc();
    load = 1'b0;
    cyc();
    n_cmp++; if (hex !== {7'h7F, 7'h7F, 7'h7F, 7'h40}) begin n_fail++; $display("FAIL blank_0000: got %h expected %h", hex, {7'h7F, 7'h7F, 7'h7F, 7'h40}); end
    n_cmp++; if (hex0 !== {7'h00, 7'h00, 7'h00, 7'h3F}) begin n_fail++; $display("FAIL blank_0000_ah: got %h expected %h", hex0, {7'h00, 7'h00, 7'h00, 7'h3F}); end
    blank_lz = 1'b0;
  endtask

  task automatic test_load_priority();
    int k;
    enable = 1'b1; up_down = 1'b1; radix_bcd = 1'b1;
    k = 0;
    while (tick !== 1'b1 && k < 2*PERIOD) begin cyc(); k++; end
    n_cmp++; if (tick !== 1'b1) begin n_fail++; $display("FAIL loadpri_tick_timeout: got tick=%b expected 1", tick); end
    load = 1'b1; load_value = 16'h12A4;
    cyc();
    load = 1'b0;
    n_cmp++; if (count !== 16'h1294 || wrap !== 1'b0) begin n_fail++; $display("FAIL load_priority: got %h wrap=%b expected 1294 wrap=0", count, wrap); end
    repeat (PERIOD - 1) cyc();
    n_cmp++; if (count !== 16'h1294 || tick !== 1'b1) begin n_fail++; $display("FAIL load_keeps_prescaler: got %h tick=%b expected 1294 tick=1", count, tick); end
    cyc();
    n_cmp++; if (count !== 16'h1295) begin n_fail++; $display("FAIL load_then_step: got %h expected 1295", count); end
  endtask

  task automatic test_enable_hold();
    int k;
    logic [15:0] held;
    enable = 1'b1; up_down = 1'b1; radix_bcd = 1'b0;
    k = 0;
    while (tick !== 1'b1 && k < 2*PERIOD) begin cyc(); k++; end
    enable = 1'b0;
    cyc();
    held = count;
    for (int c = 0; c < 10; c++) begin
      cyc();
      n_cmp++;
      if (count !== held || tick !== 1'b0) begin
        n_fail++; $display("FAIL enable_hold_%0d: got %h tick=%b expected %h tick=0", c, count, tick, held);
      end
    end
    enable = 1'b1;
    k = 0;
    do begin cyc(); k++; end while (tick !== 1'b1 && k < 2*PERIOD);
    n_cmp++; if (k != PERIOD) begin n_fail++; $display("FAIL enable_resume: tick after %0d clocks expected %0d", k, PERIOD); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      enable = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0) up_down = ~up_down;
      if ($urandom_range(0, 31) == 0) radix_bcd = ~radix_bcd;
      blank_lz = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 3))
        0: load_value = 16'($urandom);
        1: load_value = 16'hFFFF;
        2: load_value = 16'h9999;
        default: load_value = 16'h0000;
      endcase
      cyc();
      n_cmp++;
      if ({count, hex, tick, wrap} !== {m_count, ~m_lit, m_tick, m_wrap} ||
          {count0, hex0, tick0, wrap0} !== {m_count, m_lit, m_tick, m_wrap}) begin
        n_fail++;
        $display("FAIL random_%0d: got count=%h hex=%h hex_ah=%h tick=%b wrap=%b expected count=%h hex=%h hex_ah=%h tick=%b wrap=%b",
                 n, count, hex, hex0, tick, wrap, m_count, ~m_lit, m_lit, m_tick, m_wrap);
      end
    end
    load = 1'b0;
  endtask

  initial begin
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    test_reset();
    test_bcd_wrap();
    test_hex_carry();
    test_down_wrap();
    test_blanking();
    test_load_priority();
    test_enable_hold();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
